div_unit: RTL and testbench



---
 rtl/div_unit_pkg.sv | 28 ++
 rtl/div_step.sv | 31 +++
 rtl/div_unit.sv | 137 +++++++++++++
 tb/tb_div_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared constants, state encoding and decode helper for the RV32M divider
package div_unit_pkg;

    localparam int DIV_XLEN  = 32;
    localparam int DIV_CNT_W = 6;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Decoder helper: true for DIV/DIVU/REM/REMU, the only encodings that may raise start.
    function automatic logic is_div_op(input logic [6:0] opcode,
                                       input logic [6:0] funct7,
                                       input logic [2:0] funct3);
        return (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV) && funct3[2];
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step
    import div_unit_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] q,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] q_next
);

    // The trial remainder needs XLEN+1 bits: the bit shifted out of rem can make it exceed any divisor.
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] diff;

    // Shift the next dividend bit in, subtract the divisor if it fits, and record the quotient bit.
    always_comb begin
        trial = {rem, q[XLEN-1]};
        diff  = trial[XLEN-1:0] - divisor;
        if (trial >= {1'b0, divisor}) begin
            rem_next = diff;
            q_next   = {q[XLEN-2:0], 1'b1};
        end else begin
            rem_next = trial[XLEN-1:0];
            q_next   = {q[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative RV32M divider producing a stall and one write-back beat
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN  = DIV_XLEN,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            div_stall,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    div_state_e state, state_next;

    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  rem, q, divisor;
    logic [XLEN-1:0]  rem_next, q_next;
    logic             is_rem, neg_q, neg_r;
    logic [4:0]       rd_q;

    // Start-cycle decode of the incoming operands.
    logic            go, is_rem_in, sgn_in, a_neg, b_neg, b_zero, ovf, special;
    logic [XLEN-1:0] abs_a, abs_b;

    // start only accompanies divide funct3 values; qualifying it keeps a stray MUL decode from stalling.
    assign go        = start && (funct3 inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU});
    assign is_rem_in = (funct3 == F3_REM) || (funct3 == F3_REMU);
    assign sgn_in    = (funct3 == F3_DIV) || (funct3 == F3_REM);
    assign a_neg     = sgn_in && op_a[XLEN-1];
    assign b_neg     = sgn_in && op_b[XLEN-1];
    assign abs_a     = a_neg ? -op_a : op_a;
    assign abs_b     = b_neg ? -op_b : op_b;
    assign b_zero    = (op_b == '0);
    assign ovf       = sgn_in && (op_a == INT_MIN) && (op_b == '1);
    assign special   = b_zero || ovf;

    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem),
        .q        (q),
        .divisor  (divisor),
        .rem_next (rem_next),
        .q_next   (q_next)
    );

    // State register; reset drops any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state, the stall seen by the hazard unit, and the write-back strobe.
    always_comb begin
        state_next   = state;
        div_stall    = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    div_stall  = 1'b1;
                    state_next = special ? DONE : BUSY;
                end
            end
            BUSY: begin
                div_stall = 1'b1;
                if (cnt == LAST_CNT) state_next = DONE;
            end
            DONE: begin
                result_valid = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, one restoring step per BUSY cycle, and result registration on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            rem     <= '0;
            q       <= '0;
            divisor <= '0;
            is_rem  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            rd_q    <= '0;
            result  <= '0;
            rd_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        cnt     <= '0;
                        rem     <= '0;
                        q       <= abs_a;
                        divisor <= abs_b;
                        is_rem  <= is_rem_in;
                        neg_q   <= sgn_in && (op_a[XLEN-1] ^ op_b[XLEN-1]) && !b_zero;
                        neg_r   <= a_neg;
                        rd_q    <= rd_in;
                        // Divide-by-zero and signed overflow have fixed answers and skip iteration.
                        if (b_zero) begin
                            result <= is_rem_in ? op_a : '1;
                            rd_out <= rd_in;
                        end else if (ovf) begin
                            result <= is_rem_in ? '0 : INT_MIN;
                            rd_out <= rd_in;
                        end
                    end
                end
                BUSY: begin
                    rem <= rem_next;
                    q   <= q_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        // Magnitudes were divided; signs are restored here from the captured flags.
                        if (is_rem) result <= neg_r ? -rem_next : rem_next;
                        else        result <= neg_q ? -q_next : q_next;
                        rd_out <= rd_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit against an arithmetic reference
module tb_div_unit;
    import div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [4:0]  rd_in = '0;
    logic        div_stall;
    logic        result_valid;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int done_cycle = 0;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .funct3       (funct3),
        .op_a         (op_a),
        .op_b         (op_b),
        .rd_in        (rd_in),
        .div_stall    (div_stall),
        .result_valid (result_valid),
        .result       (result),
        .rd_out       (rd_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // RISC-V M semantics computed with 64-bit arithmetic (truncating division).
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, qq, rr;
        if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        qq = sa / sb;
        rr = sa % sb;
        return f3[1] ? rr[31:0] : qq[31:0];
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input bit hold);
        int cyc;
        bit stall_ok;
        @(negedge clk);
        check({tag, "/rv_idle"}, 32'(result_valid), 32'd0);
        start = 1'b1; funct3 = f3; op_a = a; op_b = b; rd_in = rd;
        #1;
        check({tag, "/stall_start"}, 32'(div_stall), 32'd1);
        cyc = 0;
        stall_ok = 1'b1;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (!hold) begin
                start = 1'b0;
                op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom);
            end
            #1;
            if (result_valid) break;
            if (div_stall !== 1'b1) stall_ok = 1'b0;
        end
        done_cycle = cycle;
        check({tag, "/latency"}, 32'(cyc), 32'(ref_latency(f3, a, b)));
        check({tag, "/stall_held"}, 32'(stall_ok), 32'd1);
        check({tag, "/result"}, result, ref_result(f3, a, b));
        check({tag, "/rd_out"}, 32'(rd_out), 32'(rd));
        check({tag, "/stall_done"}, 32'(div_stall), 32'd0);
        start = 1'b0;
    endtask

    initial begin
        int t1;
        bit rv_seen;
        logic [2:0]  rf3;
        logic [31:0] ra, rb;

        #1;
        check("reset/stall", 32'(div_stall), 32'd0);
        check("reset/rv", 32'(result_valid), 32'd0);
        check("reset/result", result, 32'd0);
        check("reset/rd_out", 32'(rd_out), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_op("divu_100_7", F3_DIVU, 32'd100, 32'd7, 5'd3, 1'b0);
        check("divu_100_7/value", result, 32'd14);
        do_op("div_m7_2", F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b0);
        check("div_m7_2/value", result, 32'hFFFF_FFFD);
        do_op("rem_m7_2", F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b0);
        check("rem_m7_2/value", result, 32'hFFFF_FFFF);
        do_op("remu_m7_2", F3_REMU, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b0);
        check("remu_m7_2/value", result, 32'd1);
        do_op("div_5_0", F3_DIV, 32'd5, 32'd0, 5'd7, 1'b0);
        check("div_5_0/value", result, 32'hFFFF_FFFF);
        do_op("remu_5_0", F3_REMU, 32'd5, 32'd0, 5'd8, 1'b0);
        check("remu_5_0/value", result, 32'd5);
        do_op("rem_m5_0", F3_REM, 32'hFFFF_FFFB, 32'd0, 5'd9, 1'b0);
        check("rem_m5_0/value", result, 32'hFFFF_FFFB);
        do_op("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b0);
        check("div_ovf/value", result, 32'h8000_0000);
        do_op("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0);
        check("rem_ovf/value", result, 32'd0);
        do_op("divu_ovf", F3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0);
        check("divu_ovf/value", result, 32'd0);
        do_op("rd_zero", F3_DIV, 32'hFFFF_FF9C, 32'd10, 5'd0, 1'b0);
        do_op("hold_start", F3_DIVU, 32'd1000, 32'd33, 5'd13, 1'b1);

        // Reset in the middle of a BUSY operation.
        @(negedge clk);
        start = 1'b1; funct3 = F3_DIVU; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd14;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #1;
        check("rst_mid/busy_before", 32'(div_stall), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid/stall", 32'(div_stall), 32'd0);
        check("rst_mid/rv", 32'(result_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rv_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (result_valid || div_stall) rv_seen = 1'b1;
        end
        check("rst_mid/quiet", 32'(rv_seen), 32'd0);
        do_op("after_rst", F3_DIVU, 32'd9, 32'd3, 5'd15, 1'b0);
        check("after_rst/value", result, 32'd3);

        // Back-to-back: second start in the IDLE cycle right after DONE.
        do_op("b2b_first", F3_DIVU, 32'd9, 32'd3, 5'd16, 1'b0);
        t1 = done_cycle;
        do_op("b2b_second", F3_DIVU, 32'd20, 32'd4, 5'd17, 1'b0);
        check("b2b/spacing", 32'(done_cycle - t1), 32'd34);
        check("b2b/value", result, 32'd5);

        // Random operations, biased toward the corner cases.
        for (int i = 0; i < 30; i++) begin
            rf3 = 3'($urandom_range(4, 7));
            case ($urandom_range(0, 5))
                0: begin ra = $urandom; rb = 32'd0; end
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = $urandom_range(0, 200); rb = $urandom_range(1, 20); end
                3: begin ra = $urandom; rb = 32'($urandom_range(1, 1000)); end
                4: begin ra = $urandom; rb = -32'($urandom_range(1, 1000)); end
                default: begin ra = $urandom; rb = $urandom; end
            endcase
            do_op($sformatf("rand%0d", i), rf3, ra, rb, 5'($urandom), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
